// File: rtl/spi_ram_pkg.sv
// Shared sizing constants for the SPI RAM controller and the blocks that front it.
package spi_ram_pkg;

  localparam int unsigned SPI_RAM_DATA_WIDTH      = 16;
  localparam int unsigned SPI_RAM_ADDR_BITS       = 16;
  localparam int unsigned SPI_RAM_TIMEOUT_DEFAULT = 1023;

endpackage

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter serializing two masters' read/write transactions onto one
// spi_ram_controller, with per-port ack/err and a watchdog on the controller's busy.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = SPI_RAM_DATA_WIDTH,
  parameter int unsigned ADDR_BITS      = SPI_RAM_ADDR_BITS,
  parameter int unsigned TIMEOUT_CYCLES = SPI_RAM_TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_BITS-1:0]  p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_BITS-1:0]  p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic                  owner,
  output logic                  active,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_start_read,
  output logic                  ram_start_write,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  active_q, active_d;
  logic [ADDR_BITS-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  start_rd_q, start_rd_d;
  logic                  start_wr_q, start_wr_d;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
  logic                  p0_ack_q, p0_ack_d, p0_err_q, p0_err_d;
  logic                  p1_ack_q, p1_ack_d, p1_err_q, p1_err_d;
  logic                  grant_c;
  logic                  timed_out_c;

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    start_rd_d   = 1'b0;
    start_wr_d   = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    p0_ack_d     = 1'b0;
    p0_err_d     = 1'b0;
    p1_ack_d     = 1'b0;
    p1_err_d     = 1'b0;
    grant_c      = (p0_req && p1_req) ? ~last_grant_q : p1_req;
    // The watchdog fires once the count has reached the limit with busy still high.
    timed_out_c  = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    case (state_q)
      ST_IDLE: begin
        if (!ram_busy && (p0_req || p1_req)) begin
          owner_d      = grant_c;
          last_grant_d = grant_c;
          we_d         = grant_c ? p1_we : p0_we;
          ram_addr_d   = grant_c ? p1_addr : p0_addr;
          ram_wdata_d  = grant_c ? p1_wdata : p0_wdata;
          start_wr_d   = grant_c ? p1_we : p0_we;
          start_rd_d   = grant_c ? !p1_we : !p0_we;
          cnt_d        = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (!ram_busy) begin
          if (!we_q) begin
            if (owner_q) p1_rdata_d = ram_data_out;
            else         p0_rdata_d = ram_data_out;
          end
          p0_ack_d = !owner_q;
          p1_ack_d = owner_q;
          state_d  = ST_DONE;
        end else if (timed_out_c) begin
          p0_ack_d = !owner_q;
          p1_ack_d = owner_q;
          p0_err_d = !owner_q;
          p1_err_d = owner_q;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      active_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      start_rd_q   <= 1'b0;
      start_wr_q   <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      p0_ack_q     <= 1'b0;
      p0_err_q     <= 1'b0;
      p1_ack_q     <= 1'b0;
      p1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      active_q     <= active_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      start_rd_q   <= start_rd_d;
      start_wr_q   <= start_wr_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_ack_q     <= p0_ack_d;
      p0_err_q     <= p0_err_d;
      p1_ack_q     <= p1_ack_d;
      p1_err_q     <= p1_err_d;
    end
  end

  assign p0_rdata        = p0_rdata_q;
  assign p0_ack          = p0_ack_q;
  assign p0_err          = p0_err_q;
  assign p1_rdata        = p1_rdata_q;
  assign p1_ack          = p1_ack_q;
  assign p1_err          = p1_err_q;
  assign owner           = owner_q;
  assign active          = active_q;
  assign ram_addr        = ram_addr_q;
  assign ram_data_in     = ram_wdata_q;
  assign ram_start_read  = start_rd_q;
  assign ram_start_write = start_wr_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: default-timeout instance plus a TIMEOUT_CYCLES=4 instance
// driven by the same masters and a small controller model.
module tb_spi_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [15:0] ram_data_out;
  logic        ram_busy;

  logic [15:0] p0_rdata, p1_rdata, ram_addr, ram_data_in;
  logic        p0_ack, p0_err, p1_ack, p1_err, owner, active, ram_start_read, ram_start_write;
  logic [15:0] t_p0_rdata, t_p1_rdata, t_ram_addr, t_ram_data_in;
  logic        t_p0_ack, t_p0_err, t_p1_ack, t_p1_err, t_owner, t_active;
  logic        t_ram_start_read, t_ram_start_write;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_ram_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack), .p1_err(p1_err),
    .owner(owner), .active(active), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_start_read(ram_start_read), .ram_start_write(ram_start_write),
    .ram_data_out(ram_data_out), .ram_busy(ram_busy)
  );

  spi_ram_arbiter #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(t_p0_rdata), .p0_ack(t_p0_ack), .p0_err(t_p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(t_p1_rdata), .p1_ack(t_p1_ack), .p1_err(t_p1_err),
    .owner(t_owner), .active(t_active), .ram_addr(t_ram_addr), .ram_data_in(t_ram_data_in),
    .ram_start_read(t_ram_start_read), .ram_start_write(t_ram_start_write),
    .ram_data_out(ram_data_out), .ram_busy(ram_busy)
  );

  // Controller model: busy for busy_len cycles after a start, plus a bench-forced stuck busy.
  logic [15:0] mem [0:255];
  int          busy_cnt;
  int          busy_len;
  logic        force_busy;
  logic        use_m;
  logic [15:0] m_addr, m_wdata;
  logic        m_we;

  assign use_m    = ram_start_read | ram_start_write;
  assign m_addr   = use_m ? ram_addr : t_ram_addr;
  assign m_wdata  = use_m ? ram_data_in : t_ram_data_in;
  assign m_we     = use_m ? ram_start_write : t_ram_start_write;
  assign ram_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'h10]   <= 16'hBEEF;
      mem[8'h04]   <= 16'h5A5A;
      mem[8'h08]   <= 16'h7777;
      busy_cnt     <= 0;
      ram_data_out <= 16'h0000;
    end else if (use_m || t_ram_start_read || t_ram_start_write) begin
      busy_cnt <= busy_len;
      if (m_we) begin
        mem[m_addr[7:0]] <= m_wdata;
        ram_data_out     <= 16'hDEAD;
      end else begin
        ram_data_out <= mem[m_addr[7:0]];
      end
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  int glog [0:255];
  int gn = 0;
  int m_starts = 0;
  int t_starts = 0;

  always @(negedge clk) begin
    if (ram_start_read || ram_start_write) begin
      if (gn < 256) glog[gn] = 32'(owner);
      gn = gn + 1;
      m_starts = m_starts + 1;
    end
    if (t_ram_start_read || t_ram_start_write) t_starts = t_starts + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int which);
    case (which)
      0:       return p0_ack;
      1:       return p1_ack;
      2:       return t_p0_ack;
      default: return t_p1_ack;
    endcase
  endfunction

  task automatic wait_ack(input int which, input string tag, inout int n);
    int k;
    k = 0;
    while (!ack_of(which)) begin
      if (k == 200) begin
        n_vec++;
        n_err++;
        $error("FAIL %s observed=no_ack expected=ack", tag);
        return;
      end
      tick();
      n++;
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;
    force_busy = 1'b0;
    busy_len = 2;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n, a0, a1, g0, ts, ms;

    // Reset state
    do_reset();
    chk("rst_ack",   32'({p0_ack, p0_err, p1_ack, p1_err}), 32'h0);
    chk("rst_ctl",   32'({owner, active, ram_start_read, ram_start_write}), 32'h0);
    chk("rst_addr",  32'(ram_addr), 32'h0);
    chk("rst_wdata", 32'(ram_data_in), 32'h0);
    chk("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'h0);

    // Port 0 read, 5 busy cycles: ack 8 cycles after req
    busy_len = 5;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    n = 0;
    tick(); n++;
    chk("t1_start_rd", 32'({ram_start_read, ram_start_write}), 32'h2);
    chk("t1_addr",     32'(ram_addr), 32'h0010);
    chk("t1_active",   32'({active, owner}), 32'h2);
    a1 = 0;
    while (!p0_ack && n < 50) begin
      tick(); n++;
      if (p1_ack) a1++;
    end
    p0_req = 1'b0;
    chk("t1_latency", 32'(n), 32'd8);
    chk("t1_rdata",   32'(p0_rdata), 32'hBEEF);
    chk("t1_err",     32'(p0_err), 32'h0);
    chk("t1_p1_idle", 32'(a1), 32'h0);
    tick();
    chk("t1_ack_pulse", 32'({p0_ack, active}), 32'h0);
    chk("t1_rdata_hold", 32'(p0_rdata), 32'hBEEF);

    // Both request from reset: port 0 write first, port 1 read 2 cycles after p0 ack
    do_reset();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0002; p0_wdata = 16'h1234;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0004;
    tick();
    chk("t2_start_wr", 32'({ram_start_read, ram_start_write}), 32'h1);
    chk("t2_wdata",    32'(ram_data_in), 32'h1234);
    chk("t2_addr",     32'(ram_addr), 32'h0002);
    chk("t2_owner",    32'(owner), 32'h0);
    n = 0;
    wait_ack(0, "t2_p0_ack", n);
    p0_req = 1'b0;
    chk("t2_p1_noack", 32'(p1_ack), 32'h0);
    tick();
    chk("t2_gap", 32'({ram_start_read, ram_start_write}), 32'h0);
    tick();
    chk("t2_p1_start", 32'({ram_start_read, owner}), 32'h3);
    chk("t2_p1_addr",  32'(ram_addr), 32'h0004);
    wait_ack(1, "t2_p1_ack", n);
    p1_req = 1'b0;
    chk("t2_p1_rdata", 32'(p1_rdata), 32'h5A5A);
    chk("t2_p0_rdata", 32'(p0_rdata), 32'h0000);

    // Fairness with continuous requests
    do_reset();
    busy_len = 1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0004;
    a0 = 0; a1 = 0; g0 = gn;
    for (int k = 0; k < 200 && (a0 + a1) < 6; k++) begin
      tick();
      if (p0_ack) a0++;
      if (p1_ack) a1++;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
    tick();
    chk("t3_grants", 32'(gn - g0), 32'd6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_grant%0d", i), 32'(glog[g0 + i]), 32'(i % 2));
    chk("t3_acks0", 32'(a0), 32'd3);
    chk("t3_acks1", 32'(a1), 32'd3);

    // Timeout (TIMEOUT_CYCLES = 4) with busy stuck high
    do_reset();
    busy_len = 1;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0004;
    n = 0;
    tick();
    wait_ack(3, "t4_first_ack", n);
    p1_req = 1'b0;
    tick();
    chk("t4_pre_rdata", 32'(t_p1_rdata), 32'h5A5A);
    p1_req = 1'b1; p1_addr = 16'h0008;
    tick();
    chk("t4_start", 32'({t_ram_start_read, t_owner}), 32'h3);
    force_busy = 1'b1;
    n = 0;
    wait_ack(3, "t4_to_ack", n);
    chk("t4_latency", 32'(n), 32'd6);
    chk("t4_err",     32'(t_p1_err), 32'h1);
    chk("t4_rdata",   32'(t_p1_rdata), 32'h5A5A);
    p1_req = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    ts = t_starts;
    for (int k = 0; k < 5; k++) tick();
    chk("t4_no_start", 32'(t_starts - ts), 32'd0);
    chk("t4_idle",     32'(t_active), 32'h0);
    force_busy = 1'b0;
    tick();
    chk("t4_restart", 32'({t_ram_start_read, t_owner}), 32'h2);
    wait_ack(2, "t4_p0_ack", n);
    p0_req = 1'b0;
    chk("t4_p0_rdata", 32'({t_p0_rdata, 15'h0, t_p0_err}), 32'hBEEF0000);

    // Reset while the controller is busy
    do_reset();
    busy_len = 0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0010;
    tick();
    force_busy = 1'b1;
    tick();
    tick();
    chk("t5_in_wait", 32'({active, owner}), 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_ctl",  32'({owner, active, ram_start_read, ram_start_write, p1_ack, p1_err}), 32'h0);
    chk("t5_rst_addr", 32'(ram_addr), 32'h0);
    ms = m_starts;
    tick(); tick(); tick();
    chk("t5_held",      32'(m_starts - ms), 32'd0);
    chk("t5_held_idle", 32'(active), 32'h0);
    force_busy = 1'b0;
    tick();
    chk("t5_start",      32'({ram_start_read, owner}), 32'h3);
    chk("t5_start_addr", 32'(ram_addr), 32'h0010);
    n = 0;
    wait_ack(1, "t5_ack", n);
    p1_req = 1'b0;
    chk("t5_rdata", 32'({p1_rdata, 15'h0, p1_err}), 32'hBEEF0000);

    // Write then read of the same address: rdata moves only on the read ack
    do_reset();
    busy_len = 2;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0010;
    n = 0;
    tick();
    wait_ack(0, "t6_rd0_ack", n);
    chk("t6_rd0", 32'(p0_rdata), 32'hBEEF);
    p0_we = 1'b1; p0_addr = 16'h0020; p0_wdata = 16'hC0DE;
    tick();
    tick();
    chk("t6_b2b_wr", 32'({ram_start_read, ram_start_write}), 32'h1);
    wait_ack(0, "t6_wr_ack", n);
    chk("t6_wr_ack_rdata", 32'({p0_rdata, 15'h0, p0_err}), 32'hBEEF0000);
    p0_we = 1'b0;
    tick();
    chk("t6_after_wr", 32'(p0_rdata), 32'hBEEF);
    wait_ack(0, "t6_rd_ack", n);
    p0_req = 1'b0;
    chk("t6_rd_rdata", 32'(p0_rdata), 32'hC0DE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
